// File: rtl/timestamp_stream_checker.sv
// ----------------------------------------------------------------------------
// timestamp_stream_checker
//
// Compares the decoupled (data, time) sample stream of the reference
// timestamper against a model stream of value-change events. The reference
// delivers one sample per picosecond of reference time. The model delivers
// one event per value change, and each event's value holds from its
// timestamp until the next event takes effect.
//
// A one-entry lookahead register (nxt) holds the next model event. A
// reference sample is accepted only once the lookahead proves that the
// current model value still applies at the sample's time. When the
// lookahead event has become effective it is promoted into the current
// value instead, and no sample is accepted in that cycle.
//
// Ports:
//   clock                 host clock
//   reset                 synchronous, active-high reset
//   ref_valid/ref_ready   reference sample handshake
//   ref_bits_data         sampled reference value
//   ref_bits_time         sample time in ps
//   model_valid/ready     model event handshake
//   model_bits_data       model value effective from model_bits_time
//   model_bits_time       model event time in ps
//   check_limit           last reference time to check (stable out of reset)
//   done                  every sample from 0 to check_limit has been checked
//   mismatch_count        saturating count of samples where ref != model
//   first_mismatch_*      details of the first mismatching sample (sticky)
//   protocol_error        sticky stream-ordering violation
// ----------------------------------------------------------------------------
module timestamp_stream_checker #(
    parameter int unsigned DATA_WIDTH  = 1,
    parameter int unsigned TIME_WIDTH  = 64,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   ref_valid,
    output logic                   ref_ready,
    input  logic [DATA_WIDTH-1:0]  ref_bits_data,
    input  logic [TIME_WIDTH-1:0]  ref_bits_time,

    input  logic                   model_valid,
    output logic                   model_ready,
    input  logic [DATA_WIDTH-1:0]  model_bits_data,
    input  logic [TIME_WIDTH-1:0]  model_bits_time,

    input  logic [TIME_WIDTH-1:0]  check_limit,

    output logic                   done,
    output logic [COUNT_WIDTH-1:0] mismatch_count,
    output logic                   first_mismatch_valid,
    output logic [TIME_WIDTH-1:0]  first_mismatch_time,
    output logic [DATA_WIDTH-1:0]  first_mismatch_ref,
    output logic [DATA_WIDTH-1:0]  first_mismatch_model,
    output logic                   protocol_error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] STATE_INIT  = 2'd0;
    localparam logic [1:0] STATE_CHECK = 2'd1;
    localparam logic [1:0] STATE_DONE  = 2'd2;

    localparam logic [TIME_WIDTH-1:0]  TIME_ONE  = {{(TIME_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             state_q;
    logic [1:0]             state_d;

    // Current model value and the time it became effective.
    logic [DATA_WIDTH-1:0]  cur_data_q;
    logic [TIME_WIDTH-1:0]  cur_time_q;

    // Lookahead model event.
    logic                   nxt_valid_q;
    logic [DATA_WIDTH-1:0]  nxt_data_q;
    logic [TIME_WIDTH-1:0]  nxt_time_q;

    // Time the next reference sample is expected to carry.
    logic [TIME_WIDTH-1:0]  expected_time_q;

    logic [COUNT_WIDTH-1:0] mismatch_count_q;
    logic                   first_valid_q;
    logic [TIME_WIDTH-1:0]  first_time_q;
    logic [DATA_WIDTH-1:0]  first_ref_q;
    logic [DATA_WIDTH-1:0]  first_model_q;
    logic                   protocol_error_q;

    logic                   model_fire;
    logic                   ref_fire;
    logic                   promote;
    logic                   sample_mismatch;
    logic                   last_sample;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    // ref_ready looks at ref_bits_time so a sample is only accepted once the
    // lookahead shows the current model value still covers that time.
    always_comb begin
        model_ready = 1'b0;
        ref_ready   = 1'b0;
        promote     = 1'b0;
        case (state_q)
            STATE_INIT: begin
                model_ready = 1'b1;
            end
            STATE_CHECK: begin
                model_ready = !nxt_valid_q;
                promote     = nxt_valid_q && ref_valid && (nxt_time_q <= ref_bits_time);
                ref_ready   = nxt_valid_q && (nxt_time_q > ref_bits_time);
            end
            default: begin
                model_ready = 1'b0;
                ref_ready   = 1'b0;
                promote     = 1'b0;
            end
        endcase
    end

    assign model_fire      = model_valid && model_ready;
    assign ref_fire        = ref_valid && ref_ready;
    assign sample_mismatch = ref_fire && (ref_bits_data != cur_data_q);
    assign last_sample     = ref_fire && (ref_bits_time == check_limit);

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_INIT: begin
                if (model_fire) begin
                    state_d = STATE_CHECK;
                end
            end
            STATE_CHECK: begin
                if (last_sample) begin
                    state_d = STATE_DONE;
                end
            end
            STATE_DONE: begin
                state_d = STATE_DONE;
            end
            default: begin
                state_d = STATE_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= STATE_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Model value tracking: current value plus one-entry lookahead
    // ------------------------------------------------------------------------
    // The first event is used from time 0 even if it carries a later stamp;
    // its stamp is kept for the ordering check of the following event.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_data_q  <= '0;
            cur_time_q  <= '0;
            nxt_valid_q <= 1'b0;
            nxt_data_q  <= '0;
            nxt_time_q  <= '0;
        end else begin
            if (state_q == STATE_INIT && model_fire) begin
                cur_data_q <= model_bits_data;
                cur_time_q <= model_bits_time;
            end
            if (state_q == STATE_CHECK) begin
                // model_fire needs an empty lookahead and promote a full one,
                // so the two never collide.
                if (model_fire) begin
                    nxt_valid_q <= 1'b1;
                    nxt_data_q  <= model_bits_data;
                    nxt_time_q  <= model_bits_time;
                end
                if (promote) begin
                    cur_data_q  <= nxt_data_q;
                    cur_time_q  <= nxt_time_q;
                    nxt_valid_q <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference time sequencing
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            expected_time_q <= '0;
        end else if (ref_fire) begin
            expected_time_q <= expected_time_q + TIME_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Mismatch accounting
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch_count_q <= '0;
            first_valid_q    <= 1'b0;
            first_time_q     <= '0;
            first_ref_q      <= '0;
            first_model_q    <= '0;
        end else if (sample_mismatch) begin
            if (mismatch_count_q != {COUNT_WIDTH{1'b1}}) begin
                mismatch_count_q <= mismatch_count_q + COUNT_ONE;
            end
            if (!first_valid_q) begin
                first_valid_q <= 1'b1;
                first_time_q  <= ref_bits_time;
                first_ref_q   <= ref_bits_data;
                first_model_q <= cur_data_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Protocol checking (sticky)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            protocol_error_q <= 1'b0;
        end else begin
            if (state_q == STATE_INIT && model_fire && model_bits_time != '0) begin
                protocol_error_q <= 1'b1;
            end
            // Model event times must strictly increase.
            if (state_q == STATE_CHECK && model_fire && model_bits_time <= cur_time_q) begin
                protocol_error_q <= 1'b1;
            end
            // Reference samples must arrive at consecutive picoseconds.
            if (ref_fire && ref_bits_time != expected_time_q) begin
                protocol_error_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign done                 = (state_q == STATE_DONE);
    assign mismatch_count       = mismatch_count_q;
    assign first_mismatch_valid = first_valid_q;
    assign first_mismatch_time  = first_time_q;
    assign first_mismatch_ref   = first_ref_q;
    assign first_mismatch_model = first_model_q;
    assign protocol_error       = protocol_error_q;

endmodule

// File: tb/tb_timestamp_stream_checker.sv
// ----------------------------------------------------------------------------
// Testbench for timestamp_stream_checker (8-bit data, 64-bit time).
// Directed table of scenarios with hand-derived results, then randomized
// data and valid throttling against a behavioural reference model, plus a
// mid-run reset and restart.
// ----------------------------------------------------------------------------
module tb_timestamp_stream_checker;

    localparam int unsigned DW = 8;
    localparam int unsigned TW = 64;
    localparam int unsigned CW = 32;

    logic          clock;
    logic          reset;
    logic          ref_valid;
    logic          ref_ready;
    logic [DW-1:0] ref_bits_data;
    logic [TW-1:0] ref_bits_time;
    logic          model_valid;
    logic          model_ready;
    logic [DW-1:0] model_bits_data;
    logic [TW-1:0] model_bits_time;
    logic [TW-1:0] check_limit;
    logic          done;
    logic [CW-1:0] mismatch_count;
    logic          first_mismatch_valid;
    logic [TW-1:0] first_mismatch_time;
    logic [DW-1:0] first_mismatch_ref;
    logic [DW-1:0] first_mismatch_model;
    logic          protocol_error;

    timestamp_stream_checker #(
        .DATA_WIDTH  (DW),
        .TIME_WIDTH  (TW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .ref_valid            (ref_valid),
        .ref_ready            (ref_ready),
        .ref_bits_data        (ref_bits_data),
        .ref_bits_time        (ref_bits_time),
        .model_valid          (model_valid),
        .model_ready          (model_ready),
        .model_bits_data      (model_bits_data),
        .model_bits_time      (model_bits_time),
        .check_limit          (check_limit),
        .done                 (done),
        .mismatch_count       (mismatch_count),
        .first_mismatch_valid (first_mismatch_valid),
        .first_mismatch_time  (first_mismatch_time),
        .first_mismatch_ref   (first_mismatch_ref),
        .first_mismatch_model (first_mismatch_model),
        .protocol_error       (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } tok_t;

    typedef struct {
        bit            finished;
        int            fires;
        logic [TW-1:0] count;
        bit            fv;
        logic [TW-1:0] ft;
        logic [DW-1:0] fr;
        logic [DW-1:0] fm;
        bit            perr;
    } res_t;

    typedef struct {
        int            n_model;
        logic [TW-1:0] mt [4];
        logic [DW-1:0] md [4];
        logic [TW-1:0] limit;
        int            flip0;
        int            flip1;
        int            skip_idx;
        int            perr_fire;
        res_t          exp;
    } vec_t;

    tok_t m_q[$];
    tok_t r_q[$];
    vec_t vecs[6];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t a, input res_t e);
        chk({tag, ".finished"}, 64'(a.finished), 64'(e.finished));
        chk({tag, ".fires"},    64'(a.fires),    64'(e.fires));
        chk({tag, ".count"},    a.count,         e.count);
        chk({tag, ".fm_valid"}, 64'(a.fv),       64'(e.fv));
        chk({tag, ".fm_time"},  a.ft,            e.ft);
        chk({tag, ".fm_ref"},   64'(a.fr),       64'(e.fr));
        chk({tag, ".fm_model"}, 64'(a.fm),       64'(e.fm));
        chk({tag, ".perr"},     64'(a.perr),     64'(e.perr));
    endtask

    function automatic vec_t mk(input int n, input int t0, input int d0, input int t1,
                                input int d1, input int t2, input int d2, input int t3,
                                input int d3, input int limit, input int f0, input int f1,
                                input int skip, input int pf, input int fires, input int cnt,
                                input int fv, input int ft, input int fr, input int fm,
                                input int perr);
        vec_t v;
        v.n_model = n;
        v.mt[0] = 64'(t0); v.md[0] = 8'(d0);
        v.mt[1] = 64'(t1); v.md[1] = 8'(d1);
        v.mt[2] = 64'(t2); v.md[2] = 8'(d2);
        v.mt[3] = 64'(t3); v.md[3] = 8'(d3);
        v.limit = 64'(limit);
        v.flip0 = f0;
        v.flip1 = f1;
        v.skip_idx = skip;
        v.perr_fire = pf;
        v.exp.finished = 1'b1;
        v.exp.fires = fires;
        v.exp.count = 64'(cnt);
        v.exp.fv = fv[0];
        v.exp.ft = 64'(ft);
        v.exp.fr = 8'(fr);
        v.exp.fm = 8'(fm);
        v.exp.perr = perr[0];
        return v;
    endfunction

    // Model value at time t: the last event whose time is <= t; the first
    // event applies from time 0 whatever its stamp.
    function automatic logic [DW-1:0] model_value(input logic [TW-1:0] t);
        logic [DW-1:0] v;
        v = m_q[0].d;
        for (int k = 1; k < m_q.size(); k++) begin
            if (m_q[k].t <= t) v = m_q[k].d;
        end
        return v;
    endfunction

    task automatic build_ref(input logic [TW-1:0] limit, input int f0, input int f1,
                             input int skip, input bit rnd);
        r_q.delete();
        for (int i = 0; i < 2000; i++) begin
            tok_t s;
            s.t = (skip >= 0 && i >= skip) ? 64'(i + 1) : 64'(i);
            s.d = model_value(s.t);
            if (int'(s.t) == f0 || int'(s.t) == f1) s.d = s.d ^ 8'h01;
            if (rnd && $urandom_range(0, 7) == 0) s.d = s.d ^ 8'($urandom_range(1, 255));
            r_q.push_back(s);
            if (s.t == limit) break;
        end
    endtask

    // Behavioural expectation straight from the checking rules.
    function automatic res_t ref_model(input logic [TW-1:0] limit);
        res_t e;
        e = '{default: 0};
        e.finished = 1'b1;
        if (m_q[0].t != 0) e.perr = 1'b1;
        for (int k = 1; k < m_q.size(); k++) begin
            if (m_q[k].t <= m_q[k-1].t) e.perr = 1'b1;
        end
        for (int i = 0; i < r_q.size(); i++) begin
            logic [DW-1:0] mv;
            mv = model_value(r_q[i].t);
            if (r_q[i].t != 64'(i)) e.perr = 1'b1;
            if (r_q[i].d != mv) begin
                e.count = e.count + 1;
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.ft = r_q[i].t;
                    e.fr = r_q[i].d;
                    e.fm = mv;
                end
            end
            e.fires++;
            if (r_q[i].t == limit) break;
        end
        return e;
    endfunction

    task automatic do_reset(input logic [TW-1:0] limit);
        @(negedge clock);
        reset = 1'b1;
        model_valid = 1'b0;
        ref_valid = 1'b0;
        check_limit = limit;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, ".count"},    64'(mismatch_count), 64'd0);
        chk({tag, ".fm_valid"}, 64'(first_mismatch_valid), 64'd0);
        chk({tag, ".fm_time"},  first_mismatch_time, 64'd0);
        chk({tag, ".fm_ref"},   64'(first_mismatch_ref), 64'd0);
        chk({tag, ".fm_model"}, 64'(first_mismatch_model), 64'd0);
        chk({tag, ".perr"},     64'(protocol_error), 64'd0);
        chk({tag, ".done"},     64'(done), 64'd0);
        chk({tag, ".ref_ready"}, 64'(ref_ready), 64'd0);
    endtask

    // Drives m_q and r_q; valid is held until the token is accepted and never
    // looks at ready. Returns when done rises, the budget expires, or after a
    // reset injected at fire count reset_at.
    task automatic run_stream(input bit throttle, input int reset_at, input int perr_fire,
                              output res_t r);
        int mi;
        int ri;
        int fires;
        bit mfire;
        bit rfire;
        r = '{default: 0};
        mi = 0; ri = 0; fires = 0; mfire = 1'b0; rfire = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            if (mfire) begin
                mi++;
                model_valid = 1'b0;
            end
            if (rfire) begin
                ri++;
                fires++;
                ref_valid = 1'b0;
                if (perr_fire > 0 && (fires == perr_fire - 1 || fires == perr_fire))
                    chk("perr_step", 64'(protocol_error), 64'(fires == perr_fire));
            end
            mfire = 1'b0;
            rfire = 1'b0;
            if (done) begin
                r.finished = 1'b1;
                break;
            end
            if (reset_at >= 0 && fires == reset_at) begin
                reset = 1'b1;
                model_valid = 1'b0;
                ref_valid = 1'b0;
                @(posedge clock);
                @(negedge clock);
                check_cleared("midreset");
                reset = 1'b0;
                break;
            end
            if (!model_valid && mi < m_q.size() && (!throttle || $urandom_range(0, 2) != 0))
                model_valid = 1'b1;
            if (!ref_valid && ri < r_q.size() && (!throttle || $urandom_range(0, 2) != 0))
                ref_valid = 1'b1;
            if (mi < m_q.size()) begin
                model_bits_data = m_q[mi].d;
                model_bits_time = m_q[mi].t;
            end
            if (ri < r_q.size()) begin
                ref_bits_data = r_q[ri].d;
                ref_bits_time = r_q[ri].t;
            end
            #1;
            mfire = model_valid && model_ready;
            rfire = ref_valid && ref_ready;
        end
        model_valid = 1'b0;
        ref_valid = 1'b0;
        r.fires = fires;
        r.count = 64'(mismatch_count);
        r.fv = first_mismatch_valid;
        r.ft = first_mismatch_time;
        r.fr = first_mismatch_ref;
        r.fm = first_mismatch_model;
        r.perr = protocol_error;
    endtask

    initial begin
        res_t r;
        res_t ru;
        res_t rt;
        res_t e;

        reset = 1'b1;
        ref_valid = 1'b0;
        model_valid = 1'b0;
        ref_bits_data = '0;
        ref_bits_time = '0;
        model_bits_data = '0;
        model_bits_time = '0;
        check_limit = 64'd20;

        //          n  t0 d0  t1 d1  t2   d2  t3   d3 lim f0 f1 skip pf fires cnt fv ft fr fm perr
        vecs[0] = mk(3, 0, 0,  5, 1, 1000, 0,   0, 0, 20, -1, -1, -1, -1, 21, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(3, 0, 0,  5, 1, 1000, 0,   0, 0, 20,  7, -1, -1, -1, 21, 1, 1, 7, 0, 1, 0);
        vecs[2] = mk(3, 0, 0,  5, 1, 1000, 0,   0, 0, 20,  3,  9, -1, -1, 21, 2, 1, 3, 1, 0, 0);
        vecs[3] = mk(3, 4, 0, 10, 1, 1000, 0,   0, 0, 20, -1, -1, -1, -1, 21, 0, 0, 0, 0, 0, 1);
        vecs[4] = mk(4, 0, 0, 10, 1,   10, 0, 1000, 1, 20, -1, -1, -1, -1, 21, 0, 0, 0, 0, 0, 1);
        vecs[5] = mk(3, 0, 0,  5, 1, 1000, 0,   0, 0, 20,  7, -1,  2,  3, 20, 1, 1, 7, 0, 1, 1);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_cleared("reset");
        chk("reset.model_ready", 64'(model_ready), 64'd1);

        for (int v = 0; v < 6; v++) begin
            m_q.delete();
            for (int k = 0; k < vecs[v].n_model; k++) begin
                tok_t tk;
                tk.t = vecs[v].mt[k];
                tk.d = vecs[v].md[k];
                m_q.push_back(tk);
            end
            do_reset(vecs[v].limit);
            build_ref(vecs[v].limit, vecs[v].flip0, vecs[v].flip1, vecs[v].skip_idx, 1'b0);
            run_stream(1'b0, -1, vecs[v].perr_fire, r);
            cmp_res($sformatf("vec%0d", v), r, vecs[v].exp);
        end

        // Randomized data with throttled handshakes.
        m_q.delete();
        m_q.push_back('{d: 8'h0A, t: 64'd0});
        m_q.push_back('{d: 8'h0B, t: 64'd50});
        m_q.push_back('{d: 8'h0C, t: 64'd1000});
        for (int s = 0; s < 3; s++) begin
            build_ref(64'd99, -1, -1, -1, 1'b1);
            e = ref_model(64'd99);
            do_reset(64'd99);
            run_stream(1'b0, -1, -1, ru);
            cmp_res($sformatf("rnd%0d.free", s), ru, e);
            do_reset(64'd99);
            run_stream(1'b1, -1, -1, rt);
            cmp_res($sformatf("rnd%0d.thr", s), rt, ru);
        end

        // Reset in the middle of a throttled run, then restart from time 0.
        build_ref(64'd99, 20, 70, -1, 1'b0);
        e = ref_model(64'd99);
        do_reset(64'd99);
        run_stream(1'b1, 40, -1, r);
        chk("midreset.unfinished", 64'(r.finished), 64'd0);
        run_stream(1'b1, -1, -1, r);
        cmp_res("restart", r, e);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
